// File: rtl/jedro_1_defines.sv
// Shared widths, ALU select encodings, opcodes and decoder state type
// for the riscv-jedro-1 decode stage.
package jedro_1_defines;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned REG_ADDR_WIDTH = 5;
   localparam int unsigned ALU_OP_WIDTH   = 4;

   // ALU select is {funct7[5], funct3}
   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'b0000;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'b0001;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'b0010;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'b0011;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'b0100;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'b0101;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'b0110;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'b0111;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'b1000;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'b1101;

   localparam logic [6:0] OPCODE_OP    = 7'b0110011;
   localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;
   localparam logic [6:0] OPCODE_LUI   = 7'b0110111;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

endpackage

// File: rtl/jedro_1_imm_gen.sv
// Combinational immediate extraction for the integer-ALU instruction class.
module jedro_1_imm_gen
   import jedro_1_defines::*;
(
   input  logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] imm,
   output logic                  use_imm
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign unused_bits = ^instr[11:7];

   always_comb begin
      imm     = '0;
      use_imm = 1'b0;
      case (opcode)
         OPCODE_OPIMM: begin
            use_imm = 1'b1;
            // shifts carry only shamt; funct7 bits are not part of the operand
            if (funct3 == 3'b001 || funct3 == 3'b101)
               imm = {27'b0, instr[24:20]};
            else
               imm = {{20{instr[31]}}, instr[31:20]};
         end
         OPCODE_LUI: begin
            use_imm = 1'b1;
            imm     = {instr[31:12], 12'b0};
         end
         default: begin
            imm     = '0;
            use_imm = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/jedro_1_decoder.sv
// Decode stage: valid/ready input from fetch, registered ALU control out,
// halts on illegal encodings until flushed.
module jedro_1_decoder
   import jedro_1_defines::*;
(
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic [DATA_WIDTH-1:0]     instr_i,
   input  logic                      instr_valid_i,
   output logic                      ready_co,
   input  logic                      flush_i,
   input  logic                      alu_ready_i,
   output logic                      valid_ro,
   output logic [ALU_OP_WIDTH-1:0]   alu_sel_ro,
   output logic [REG_ADDR_WIDTH-1:0] rs1_addr_ro,
   output logic [REG_ADDR_WIDTH-1:0] rs2_addr_ro,
   output logic [DATA_WIDTH-1:0]     imm_ro,
   output logic                      use_imm_ro,
   output logic [REG_ADDR_WIDTH-1:0] rd_addr_ro,
   output logic                      illegal_instr_ro
);

   state_t                    state_q, state_d;
   logic [6:0]                opcode;
   logic [2:0]                funct3;
   logic [6:0]                funct7;
   logic                      accept;
   logic                      legal;
   logic [ALU_OP_WIDTH-1:0]   sel;
   logic [REG_ADDR_WIDTH-1:0] rs1;
   logic [DATA_WIDTH-1:0]     imm;
   logic                      use_imm;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   jedro_1_imm_gen imm_gen_inst (
      .instr   (instr_i),
      .imm     (imm),
      .use_imm (use_imm)
   );

   assign ready_co = (state_q == RUN) && !flush_i && (!valid_ro || alu_ready_i);
   assign accept   = instr_valid_i && ready_co;

   always_comb begin
      legal = 1'b0;
      sel   = {funct7[5], funct3};
      rs1   = instr_i[19:15];
      case (opcode)
         OPCODE_OP:
            legal = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
         OPCODE_OPIMM: begin
            case (funct3)
               3'b001: begin
                  legal = (funct7 == 7'b0000000);
                  sel   = ALU_SLL;
               end
               3'b101: begin
                  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                  sel   = {funct7[5], 3'b101};
               end
               default: begin
                  legal = 1'b1;
                  sel   = {1'b0, funct3};
               end
            endcase
         end
         OPCODE_LUI: begin
            legal = 1'b1;
            sel   = ALU_ADD;
            rs1   = '0;
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (flush_i)
         state_d = RUN;
      else if (accept && !legal)
         state_d = HALT;
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         valid_ro         <= 1'b0;
         illegal_instr_ro <= 1'b0;
         alu_sel_ro       <= ALU_ADD;
         rs1_addr_ro      <= '0;
         rs2_addr_ro      <= '0;
         imm_ro           <= '0;
         use_imm_ro       <= 1'b0;
         rd_addr_ro       <= '0;
      end else if (flush_i) begin
         valid_ro         <= 1'b0;
         illegal_instr_ro <= 1'b0;
      end else if (accept) begin
         if (legal) begin
            valid_ro    <= 1'b1;
            alu_sel_ro  <= sel;
            rs1_addr_ro <= rs1;
            rs2_addr_ro <= instr_i[24:20];
            imm_ro      <= imm;
            use_imm_ro  <= use_imm;
            rd_addr_ro  <= instr_i[11:7];
         end else begin
            valid_ro         <= 1'b0;
            illegal_instr_ro <= 1'b1;
         end
      end else if (alu_ready_i) begin
         valid_ro <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jedro_1_decoder.sv
// Directed and randomized checks of jedro_1_decoder against a behavioural
// model of the decode rules and handshake.
module tb_jedro_1_decoder;

   logic        clk = 1'b0;
   logic        rstn_i;
   logic [31:0] instr_i;
   logic        instr_valid_i;
   logic        ready_co;
   logic        flush_i;
   logic        alu_ready_i;
   logic        valid_ro;
   logic [3:0]  alu_sel_ro;
   logic [4:0]  rs1_addr_ro;
   logic [4:0]  rs2_addr_ro;
   logic [31:0] imm_ro;
   logic        use_imm_ro;
   logic [4:0]  rd_addr_ro;
   logic        illegal_instr_ro;

   int checks   = 0;
   int failures = 0;

   // expected architectural view of the decoder outputs
   logic        m_valid, m_illegal, m_halt, m_use_imm;
   logic [3:0]  m_sel;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [31:0] m_imm;

   always #5 clk = ~clk;

   jedro_1_decoder dut (
      .clk_i            (clk),
      .rstn_i           (rstn_i),
      .instr_i          (instr_i),
      .instr_valid_i    (instr_valid_i),
      .ready_co         (ready_co),
      .flush_i          (flush_i),
      .alu_ready_i      (alu_ready_i),
      .valid_ro         (valid_ro),
      .alu_sel_ro       (alu_sel_ro),
      .rs1_addr_ro      (rs1_addr_ro),
      .rs2_addr_ro      (rs2_addr_ro),
      .imm_ro           (imm_ro),
      .use_imm_ro       (use_imm_ro),
      .rd_addr_ro       (rd_addr_ro),
      .illegal_instr_ro (illegal_instr_ro)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic ref_decode(input logic [31:0] w, output logic legal, output logic [3:0] sel,
                             output logic [4:0] rs1, output logic [31:0] imm, output logic use_imm);
      int unsigned f3 = w[14:12];
      int unsigned f7 = w[31:25];
      bit is_shift = (f3 == 1) || (f3 == 5);
      legal = 1'b0;
      sel = 4'(f3);
      rs1 = w[19:15];
      imm = 32'h0;
      use_imm = 1'b0;
      if (w[6:0] == 7'h33) begin
         legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
         sel = 4'(f3 + (f7 == 32 ? 8 : 0));
      end else if (w[6:0] == 7'h13) begin
         use_imm = 1'b1;
         if (f3 == 1)      legal = (f7 == 0);
         else if (f3 == 5) legal = (f7 == 0) || (f7 == 32);
         else              legal = 1'b1;
         if (f3 == 5 && f7 == 32) sel = 4'd13;
         if (is_shift) imm = 32'(w[24:20]);
         else          imm = (w[31] ? 32'hFFFF_F000 : 32'h0) | 32'(w[31:20]);
      end else if (w[6:0] == 7'h37) begin
         legal = 1'b1;
         sel = 4'd0;
         rs1 = 5'd0;
         use_imm = 1'b1;
         imm = w & 32'hFFFF_F000;
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_illegal = 0; m_halt = 0; m_use_imm = 0;
      m_sel = 4'd0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_imm = 32'd0;
   endtask

   task automatic check_outputs();
      check("valid_ro", valid_ro, m_valid);
      check("illegal_instr_ro", illegal_instr_ro, m_illegal);
      if (m_valid) begin
         check("alu_sel_ro", alu_sel_ro, m_sel);
         check("rs1_addr_ro", rs1_addr_ro, m_rs1);
         check("rd_addr_ro", rd_addr_ro, m_rd);
         check("use_imm_ro", use_imm_ro, m_use_imm);
         if (m_use_imm) check("imm_ro", imm_ro, m_imm);
         else           check("rs2_addr_ro", rs2_addr_ro, m_rs2);
      end
   endtask

   // one clock cycle: drive, check ready, advance model, check registered outputs
   task automatic step(input logic [31:0] w, input logic iv, input logic fl,
                       input logic ar, input logic rn);
      logic exp_ready, legal, use_imm;
      logic [3:0] sel;
      logic [4:0] rs1;
      logic [31:0] imm;
      instr_i = w; instr_valid_i = iv; flush_i = fl; alu_ready_i = ar; rstn_i = rn;
      #3;
      exp_ready = !m_halt && !fl && (!m_valid || ar);
      check("ready_co", ready_co, exp_ready);
      if (!rn) model_reset();
      else if (fl) begin
         m_valid = 0; m_illegal = 0; m_halt = 0;
      end else if (iv && exp_ready) begin
         ref_decode(w, legal, sel, rs1, imm, use_imm);
         if (legal) begin
            m_valid = 1; m_sel = sel; m_rs1 = rs1; m_rs2 = w[24:20];
            m_imm = imm; m_use_imm = use_imm; m_rd = w[11:7];
         end else begin
            m_valid = 0; m_illegal = 1; m_halt = 1;
         end
      end else if (ar) m_valid = 0;
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      int unsigned k = $urandom_range(0, 9);
      int unsigned j = $urandom_range(0, 3);
      if (k <= 2)      w[6:0] = 7'h33;
      else if (k <= 5) w[6:0] = 7'h13;
      else if (k <= 7) w[6:0] = 7'h37;
      if (j == 0)      w[31:25] = 7'h00;
      else if (j == 1) w[31:25] = 7'h20;
      return w;
   endfunction

   initial begin
      rstn_i = 0; instr_i = '0; instr_valid_i = 0; flush_i = 0; alu_ready_i = 0;
      model_reset();
      @(posedge clk);
      #1;
      step(32'h0, 0, 0, 0, 0);
      check("reset alu_sel_ro", alu_sel_ro, 32'h0);
      check("reset imm_ro", imm_ro, 32'h0);
      check("reset use_imm_ro", use_imm_ro, 32'h0);
      check("reset rd_addr_ro", rd_addr_ro, 32'h0);

      step(32'h0050_0093, 1, 0, 1, 1);   // addi x1,x0,5
      check("addi valid", valid_ro, 32'h1);
      check("addi imm", imm_ro, 32'h5);
      check("addi rd", rd_addr_ro, 32'h1);
      step(32'hFFF0_8093, 1, 0, 1, 1);   // addi x1,x1,-1
      check("addi neg imm", imm_ro, 32'hFFFF_FFFF);
      check("addi neg rs1", rs1_addr_ro, 32'h1);
      step(32'h4020_81B3, 1, 0, 1, 1);   // sub x3,x1,x2
      check("sub sel", alu_sel_ro, 32'h8);
      check("sub rs2", rs2_addr_ro, 32'h2);
      check("sub use_imm", use_imm_ro, 32'h0);
      step(32'h4033_5293, 1, 0, 1, 1);   // srai x5,x6,3
      check("srai sel", alu_sel_ro, 32'hD);
      check("srai imm", imm_ro, 32'h3);
      step(32'h1234_53B7, 1, 0, 1, 1);   // lui x7,0x12345
      check("lui imm", imm_ro, 32'h1234_5000);
      check("lui rs1", rs1_addr_ro, 32'h0);
      check("lui rd", rd_addr_ro, 32'h7);

      // backpressure, then accept without a bubble
      step(32'h0050_0093, 1, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         step(32'h4020_81B3, 1, 0, 0, 1);
         check("bp hold rd", rd_addr_ro, 32'h1);
      end
      step(32'h4020_81B3, 1, 0, 1, 1);
      check("bp release rd", rd_addr_ro, 32'h3);

      // illegal encoding halts until flushed
      step(32'h0000_0000, 1, 0, 1, 1);
      check("illegal flag", illegal_instr_ro, 32'h1);
      for (int i = 0; i < 5; i++) step(32'h0050_0093, 1, 0, 1, 1);
      step(32'h0050_0093, 1, 1, 1, 1);
      check("flush clears illegal", illegal_instr_ro, 32'h0);
      step(32'h0, 0, 0, 1, 1);

      // flush drops a same-cycle instruction
      step(32'h0050_0093, 1, 1, 1, 1);
      check("flush drop valid", valid_ro, 32'h0);

      // reset while stalled with valid output
      step(32'hFFF0_8093, 1, 0, 1, 1);
      step(32'h0, 0, 0, 0, 1);
      step(32'h0, 0, 0, 0, 0);
      check("rst mid valid", valid_ro, 32'h0);
      check("rst mid imm", imm_ro, 32'h0);
      check("rst mid rs1", rs1_addr_ro, 32'h0);

      for (int i = 0; i < 4000; i++) begin
         logic iv, fl, ar, rn;
         iv = ($urandom_range(0, 3) != 0);
         ar = ($urandom_range(0, 2) != 0);
         fl = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         rn = ($urandom_range(0, 63) != 0);
         step(rand_instr(), iv, fl, ar, rn);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jedro_1_decoder.md
Name: jedro_1_decoder

Overview:
- Decode stage of riscv-jedro-1, directly downstream of the instruction fetch unit.
- Accepts 32-bit instructions over a valid/ready handshake (its ready drives the fetch unit's decoder_ready_i).
- Decodes the RV32I integer-ALU class (OP, OP-IMM, LUI) into registered ALU control for the execute stage.
- Flags any other encoding as illegal and halts until flushed.

Parameters:
- DATA_WIDTH, 32, instruction/immediate width (from jedro_1_defines)
- REG_ADDR_WIDTH, 5, register file address width
- ALU_OP_WIDTH, 4, ALU operation select width

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, synchronous, active-low
- instr_i  in  DATA_WIDTH  instruction from fetch unit
- instr_valid_i  in  1  instr_i valid
- ready_co  out  1  decoder can accept instr_i this cycle (combinational)
- flush_i  in  1  discard pending output, leave HALT
- alu_ready_i  in  1  execute stage accepts current output
- valid_ro  out  1  decoded output valid
- alu_sel_ro  out  ALU_OP_WIDTH  ALU operation
- rs1_addr_ro  out  REG_ADDR_WIDTH  operand A register
- rs2_addr_ro  out  REG_ADDR_WIDTH  operand B register (don't-care when use_imm)
- imm_ro  out  DATA_WIDTH  sign-extended/shifted immediate
- use_imm_ro  out  1  operand B is imm_ro
- rd_addr_ro  out  REG_ADDR_WIDTH  write-back register
- illegal_instr_ro  out  1  unsupported/illegal instruction seen (sticky in HALT)

Behaviour:
- Reset values: valid_ro=0, illegal_instr_ro=0, alu_sel_ro=ALU_ADD, all addresses 0, imm_ro=0, use_imm_ro=0, state=RUN.
- States: RUN, HALT.
- ready_co = (state==RUN) && !flush_i && (!valid_ro || alu_ready_i).
- Accept = instr_valid_i && ready_co. Registered outputs update on the following edge; latency is 1 cycle.
- No accept and alu_ready_i=1: valid_ro clears.
- No accept and alu_ready_i=0: all outputs hold.
- ALU select = {funct7[5], funct3}. Constants: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
- OP (0110011):
  - use_imm=0.
  - funct7 must be 0000000, or 0100000 with funct3 000/101 only; otherwise illegal.
- OP-IMM (0010011):
  - use_imm=1, imm = sign-extended instr[31:20].
  - funct3 000/010/011/100/110/111: select = {0, funct3}; funct7 is ignored.
  - funct3 001: funct7 must be 0000000.
  - funct3 101: funct7 must be 0000000 or 0100000; select = {funct7[5], 101}.
  - Shifts: imm = {27'b0, shamt}.
- LUI (0110111): select=ADD, rs1=0, use_imm=1, imm={instr[31:12],12'b0}.
- Illegal: any other opcode, instr[1:0]!=11, or a funct7 violation.
  - On accept: valid_ro=0, illegal_instr_ro=1, state→HALT.
  - In HALT, ready_co=0 and illegal_instr_ro stays 1.
- flush_i (any state):
  - Next edge: valid_ro=0, illegal_instr_ro=0, state→RUN.
  - Same-cycle instr_i is not accepted; flush has priority over accept and over alu_ready_i.
- Reset mid-operation: all outputs return to reset values next edge regardless of handshake state.
- rd=x0 is legal and passed through unchanged; write suppression belongs to the register file.

Decomposition:
- jedro_1_defines package: DATA_WIDTH, REG_ADDR_WIDTH, ALU_OP_WIDTH, ALU_* select constants, OPCODE_OP/OPCODE_OPIMM/OPCODE_LUI constants, the decoder state enum.
- Sub-module jedro_1_imm_gen: combinational instr → {imm, use_imm} extraction.
- Handshake, state machine and legality checks stay in jedro_1_decoder.

Test Plan:
- addi x1,x0,5 (0x00500093), alu_ready_i=1 → next cycle: valid_ro=1, sel=0000, rs1=0, imm=0x00000005, use_imm=1, rd=1.
- addi x1,x1,-1 (0xFFF08093) → imm=0xFFFFFFFF, rs1=1. sub x3,x1,x2 (0x402081B3) → sel=1000, rs1=1, rs2=2, use_imm=0, rd=3.
- srai x5,x6,3 (0x40335293) → sel=1101, imm=0x00000003, rd=5. lui x7,0x12345 (0x123453B7) → sel=0000, rs1=0, imm=0x12345000, rd=7.
- Backpressure: hold alu_ready_i=0 for 3 cycles after an accepted addi → ready_co=0 and outputs stable all 3 cycles. Raise alu_ready_i with the next instruction valid → it is accepted that same cycle, no bubble.
- Illegal 0x00000000 → illegal_instr_ro=1, valid_ro=0, ready_co=0 for 5 cycles with instr_valid_i=1. Pulse flush_i → next cycle illegal_instr_ro=0, ready_co=1.
- Flush with an instruction valid and ready in the same cycle → that instruction is dropped, valid_ro=0. Reset asserted while valid_ro=1 and alu_ready_i=0 → all outputs at reset values next edge.
